// File: rtl/i2c_bus_clear.sv
// i2c_bus_clear
//    Sits between an upstream I2C master/mux and the physical bus. In normal
//    operation it forwards the upstream open-drain drive to the bus and returns
//    the bus state upstream. When a slave holds SDA low while SCL idles high,
//    whether detected automatically or requested with force_clear, it takes
//    over the bus. It clocks SCL until SDA is released or MAX_PULSES pulses
//    have been tried. After a release it issues a STOP condition.
//
// Parameters
//    PRESCALE       clk cycles per generated SCL half-period (>= 2)
//    STUCK_TIMEOUT  consecutive stuck cycles before automatic recovery (>= 2)
//    MAX_PULSES     SCL pulses attempted before declaring failure
//
// Ports
//    clk, rst                        clock, synchronous active-high reset
//    mux_scl_o/t, mux_sda_o/t        upstream drive (t=1 released)
//    mux_scl_i, mux_sda_i            bus state returned upstream
//    scl_i, sda_i                    asynchronous bus pins
//    scl_o/t, sda_o/t                bus drive (o fixed 0, t=0 pulls low)
//    enable                          arms automatic stuck detection
//    force_clear                     single-cycle recovery request
//    busy                            high whenever not passing through
//    stuck                           sticky failed-recovery flag
//    clear_done, clear_fail          single-cycle completion pulses
module i2c_bus_clear #(
   parameter int PRESCALE      = 125,
   parameter int STUCK_TIMEOUT = 100000,
   parameter int MAX_PULSES    = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic mux_scl_o,
   input  logic mux_scl_t,
   input  logic mux_sda_o,
   input  logic mux_sda_t,
   output logic mux_scl_i,
   output logic mux_sda_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_o,
   output logic scl_t,
   output logic sda_o,
   output logic sda_t,
   input  logic enable,
   input  logic force_clear,
   output logic busy,
   output logic stuck,
   output logic clear_done,
   output logic clear_fail
);

   localparam int PRE_W = $clog2(PRESCALE);
   localparam int STK_W = $clog2(STUCK_TIMEOUT);
   localparam int PC_W  = (MAX_PULSES < 1) ? 1 : $clog2(MAX_PULSES + 1);

   localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(PRESCALE - 1);
   localparam logic [STK_W-1:0] STK_LAST   = STK_W'(STUCK_TIMEOUT - 1);
   localparam logic [PC_W-1:0]  PC_MAX     = PC_W'(MAX_PULSES);

   typedef enum logic [2:0] {
      PASS,
      PULSE_LOW,
      PULSE_HIGH,
      STOP_A,
      STOP_B,
      STOP_C
   } state_t;

   state_t           state, next_state;
   logic [PRE_W-1:0] pre_cnt, pre_next;
   logic [PC_W-1:0]  pulse_cnt, pulse_next, pulse_inc;
   logic [STK_W-1:0] stuck_cnt, stuck_next;
   logic             scl_meta, scl_sync, sda_meta, sda_sync;
   logic             bus_stuck;
   logic             scl_t_next, sda_t_next, mux_scl_i_next, mux_sda_i_next;
   logic             done_next, fail_next, stuck_flag_next;

   // The open-drain outputs only ever pull low, so the data bits are constant.
   assign scl_o = 1'b0;
   assign sda_o = 1'b0;

   // Two-flop synchronizer for the asynchronous bus pins. The flops reset to
   // the idle (high) level so that a reset never looks like a stuck bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_meta <= 1'b1;
         scl_sync <= 1'b1;
         sda_meta <= 1'b1;
         sda_sync <= 1'b1;
      end else begin
         scl_meta <= scl_i;
         scl_sync <= scl_meta;
         sda_meta <= sda_i;
         sda_sync <= sda_meta;
      end
   end

   // Next-state logic. The bus counts as stuck only when upstream is not
   // itself holding SDA, so a long upstream START is never mistaken for a
   // hung slave. Outputs are derived from next_state, which keeps the
   // registered pin drive aligned with the state register.
   always_comb begin
      next_state      = state;
      pre_next        = pre_cnt;
      pulse_next      = pulse_cnt;
      pulse_inc       = pulse_cnt + 1'b1;
      stuck_next      = '0;
      done_next       = 1'b0;
      fail_next       = 1'b0;
      stuck_flag_next = stuck;
      bus_stuck       = !sda_sync && scl_sync && (mux_sda_t || mux_sda_o);

      if (state == PASS) begin
         if (bus_stuck) begin
            stuck_next = (stuck_cnt == STK_LAST) ? stuck_cnt : stuck_cnt + 1'b1;
         end
         if (force_clear || (enable && bus_stuck && stuck_cnt == STK_LAST)) begin
            next_state = PULSE_LOW;
            pre_next   = PRE_RELOAD;
            pulse_next = '0;
            stuck_next = '0;
         end
      end else if (pre_cnt != '0) begin
         pre_next = pre_cnt - 1'b1;
      end else begin
         pre_next = PRE_RELOAD;
         case (state)
            PULSE_LOW:  next_state = PULSE_HIGH;
            PULSE_HIGH: begin
               if (sda_sync) begin
                  next_state = STOP_A;
               end else begin
                  pulse_next = pulse_inc;
                  if (pulse_inc == PC_MAX) begin
                     next_state      = PASS;
                     fail_next       = 1'b1;
                     stuck_flag_next = 1'b1;
                  end else begin
                     next_state = PULSE_LOW;
                  end
               end
            end
            STOP_A:     next_state = STOP_B;
            STOP_B:     next_state = STOP_C;
            STOP_C: begin
               next_state      = PASS;
               done_next       = 1'b1;
               stuck_flag_next = 1'b0;
            end
            default:    next_state = PASS;
         endcase
      end

      // During recovery upstream sees SCL held low (clock stretch) and the
      // live SDA state; its drive is ignored.
      scl_t_next     = 1'b1;
      sda_t_next     = 1'b1;
      mux_scl_i_next = 1'b0;
      mux_sda_i_next = sda_sync;
      case (next_state)
         PASS: begin
            scl_t_next     = mux_scl_t | mux_scl_o;
            sda_t_next     = mux_sda_t | mux_sda_o;
            mux_scl_i_next = scl_sync;
         end
         PULSE_LOW:  scl_t_next = 1'b0;
         STOP_A: begin
            scl_t_next = 1'b0;
            sda_t_next = 1'b0;
         end
         STOP_B:     sda_t_next = 1'b0;
         default: begin
            scl_t_next = 1'b1;
            sda_t_next = 1'b1;
         end
      endcase
   end

   // State, counters and registered outputs. Reset releases both lines on
   // the very next edge, even in the middle of a recovery.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= PASS;
         pre_cnt    <= '0;
         pulse_cnt  <= '0;
         stuck_cnt  <= '0;
         scl_t      <= 1'b1;
         sda_t      <= 1'b1;
         mux_scl_i  <= 1'b1;
         mux_sda_i  <= 1'b1;
         busy       <= 1'b0;
         stuck      <= 1'b0;
         clear_done <= 1'b0;
         clear_fail <= 1'b0;
      end else begin
         state      <= next_state;
         pre_cnt    <= pre_next;
         pulse_cnt  <= pulse_next;
         stuck_cnt  <= stuck_next;
         scl_t      <= scl_t_next;
         sda_t      <= sda_t_next;
         mux_scl_i  <= mux_scl_i_next;
         mux_sda_i  <= mux_sda_i_next;
         busy       <= (next_state != PASS);
         stuck      <= stuck_flag_next;
         clear_done <= done_next;
         clear_fail <= fail_next;
      end
   end

endmodule

// File: tb/tb_i2c_bus_clear.sv
// tb_i2c_bus_clear
//    Drives i2c_bus_clear with an open-drain bus model and a misbehaving slave
//    that holds SDA low until it has seen a chosen number of SCL rising edges.
//    Each expected recovery outcome is queued when its stimulus is issued, and
//    a monitor compares it when the DUT reports completion.
module tb_i2c_bus_clear;

   localparam int PRESCALE      = 4;
   localparam int STUCK_TIMEOUT = 32;
   localparam int MAX_PULSES    = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mux_scl_o = 1'b0, mux_scl_t = 1'b1, mux_sda_o = 1'b0, mux_sda_t = 1'b1;
   logic mux_scl_i, mux_sda_i;
   logic scl_i, sda_i;
   logic scl_o, scl_t, sda_o, sda_t;
   logic enable = 1'b0, force_clear = 1'b0;
   logic busy, stuck, clear_done, clear_fail;

   logic ext_scl = 1'b1, ext_sda = 1'b1;
   logic slave_hold = 1'b0;
   int   slave_release_n = 0;
   int   slave_edges = 0;

   int checks = 0;
   int failures = 0;
   int pushes = 0;
   int completions = 0;

   typedef struct {
      bit fail;
      int pulses;
      bit stop;
   } exp_t;
   exp_t exp_q[$];

   i2c_bus_clear #(
      .PRESCALE(PRESCALE),
      .STUCK_TIMEOUT(STUCK_TIMEOUT),
      .MAX_PULSES(MAX_PULSES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mux_scl_o(mux_scl_o),
      .mux_scl_t(mux_scl_t),
      .mux_sda_o(mux_sda_o),
      .mux_sda_t(mux_sda_t),
      .mux_scl_i(mux_scl_i),
      .mux_sda_i(mux_sda_i),
      .scl_i(scl_i),
      .sda_i(sda_i),
      .scl_o(scl_o),
      .scl_t(scl_t),
      .sda_o(sda_o),
      .sda_t(sda_t),
      .enable(enable),
      .force_clear(force_clear),
      .busy(busy),
      .stuck(stuck),
      .clear_done(clear_done),
      .clear_fail(clear_fail)
   );

   // Wired-AND bus: the DUT drive combined with the external (slave) drive.
   assign scl_i = scl_t & ext_scl;
   assign sda_i = sda_t & ext_sda;

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic up_scl_t, input logic up_scl_o,
                                input logic up_sda_t, input logic up_sda_o);
      mux_scl_t = up_scl_t;
      mux_scl_o = up_scl_o;
      mux_sda_t = up_sda_t;
      mux_sda_o = up_sda_o;
   endtask

   task automatic waitBusy(output int lat, input int budget);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (busy !== 1'b1 && lat < budget);
   endtask

   task automatic waitCompletion(output int n, input int budget);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (clear_done !== 1'b1 && clear_fail !== 1'b1 && n < budget);
   endtask

   // Reference outcome of a recovery against a slave that lets go after
   // release_n SCL rising edges: one pulse per edge it needs, capped by
   // MAX_PULSES, with a STOP only if it let go in time.
   function automatic exp_t modelRecovery(input int release_n);
      exp_t e;
      e.fail   = (release_n > MAX_PULSES);
      e.pulses = e.fail ? MAX_PULSES : ((release_n < 1) ? 1 : release_n);
      e.stop   = !e.fail;
      return e;
   endfunction

   // Misbehaving slave: holds SDA low until it has counted release_n rising
   // edges on the bus SCL.
   initial begin : slave
      logic prev_scl;
      prev_scl = 1'b1;
      forever begin
         @(negedge clk);
         if (slave_hold && !prev_scl && scl_i === 1'b1) begin
            slave_edges++;
            if (slave_edges >= slave_release_n) begin
               slave_hold = 1'b0;
               ext_sda    = 1'b1;
            end
         end
         prev_scl = (scl_i === 1'b1);
      end
   end

   // Monitor: summarises each busy period (pulses, STOP, low-phase length,
   // upstream clock stretch) and scores it when clear_done/clear_fail fires.
   initial begin : monitor
      int   pulses, low_len;
      bit   stop_seen, len_ok, hold_ok;
      logic prev_busy, prev_scl_t;
      exp_t e;
      prev_busy = 1'b0;
      prev_scl_t = 1'b1;
      pulses = 0; low_len = 0; stop_seen = 0; len_ok = 1; hold_ok = 1;
      forever begin
         @(negedge clk);
         if (rst) begin
            pulses = 0; low_len = 0; stop_seen = 0; len_ok = 1; hold_ok = 1;
            prev_busy = 1'b0;
            prev_scl_t = 1'b1;
         end else begin
            if (busy === 1'b1 && prev_busy !== 1'b1) begin
               pulses = 0; low_len = 0; stop_seen = 0; len_ok = 1; hold_ok = 1;
            end
            if (busy === 1'b1) begin
               if (mux_scl_i !== 1'b0) hold_ok = 0;
               if (prev_scl_t === 1'b1 && scl_t === 1'b0) begin
                  if (sda_t === 1'b1) pulses++;
                  else stop_seen = 1;
               end
               if (scl_t === 1'b0 && sda_t === 1'b1) begin
                  low_len++;
               end else if (low_len != 0) begin
                  if (low_len != PRESCALE) len_ok = 0;
                  low_len = 0;
               end
            end
            if (clear_done === 1'b1 || clear_fail === 1'b1) begin
               completions++;
               checkOutput("completion_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  checkOutput("clear_fail", clear_fail, e.fail);
                  checkOutput("clear_done", clear_done, !e.fail);
                  checkOutput("pulse_count", pulses, e.pulses);
                  checkOutput("stop_issued", stop_seen, e.stop);
                  checkOutput("low_phase_len", len_ok, 1);
                  checkOutput("upstream_stretch", hold_ok, 1);
                  checkOutput("stuck_flag", stuck, e.fail);
                  checkOutput("busy_at_end", busy, 0);
               end
            end
            prev_busy  = busy;
            prev_scl_t = scl_t;
         end
      end
   end

   task automatic runSlaveRecovery(input int release_n, input bit drop_enable);
      int lat;
      exp_q.push_back(modelRecovery(release_n));
      pushes++;
      @(negedge clk);
      slave_edges     = 0;
      slave_release_n = release_n;
      slave_hold      = 1'b1;
      ext_sda         = 1'b0;
      waitBusy(lat, 4 * STUCK_TIMEOUT);
      checkOutput("auto_busy_latency", lat, 2 + STUCK_TIMEOUT);
      if (drop_enable) enable = 1'b0;
      waitCompletion(lat, 400);
      checkOutput("auto_completed", clear_done | clear_fail, 1);
      enable = 1'b1;
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got time limit, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic hist_scl[$];
      logic hist_sda[$];
      logic exp_scl, exp_sda;
      logic r_st, r_so, r_dt, r_do;
      int   lat, busy_cycles, pulses_seen;

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rst_scl_t", scl_t, 1);
      checkOutput("rst_sda_t", sda_t, 1);
      checkOutput("rst_scl_o", scl_o, 0);
      checkOutput("rst_sda_o", sda_o, 0);
      checkOutput("rst_mux_scl_i", mux_scl_i, 1);
      checkOutput("rst_mux_sda_i", mux_sda_i, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_stuck", stuck, 0);
      checkOutput("rst_clear_done", clear_done, 0);
      checkOutput("rst_clear_fail", clear_fail, 0);
      rst = 1'b0;
      enable = 1'b1;
      repeat (5) @(negedge clk);

      // Passthrough with random upstream drive on a healthy bus.
      $display("[TB] passthrough");
      hist_scl = '{1'b1, 1'b1, 1'b1};
      hist_sda = '{1'b1, 1'b1, 1'b1};
      exp_scl = 1'b1;
      exp_sda = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checkOutput("pass_scl_t", scl_t, exp_scl);
         checkOutput("pass_sda_t", sda_t, exp_sda);
         checkOutput("pass_mux_scl_i", mux_scl_i, hist_scl[i]);
         checkOutput("pass_mux_sda_i", mux_sda_i, hist_sda[i]);
         checkOutput("pass_busy", busy, 0);
         hist_scl.push_back(exp_scl);
         hist_sda.push_back(exp_sda);
         r_st = 1'($urandom_range(0, 1));
         r_so = ($urandom_range(0, 3) == 0);
         r_dt = 1'($urandom_range(0, 1));
         r_do = ($urandom_range(0, 3) == 0);
         applyStimulus(r_st, r_so, r_dt, r_do);
         exp_scl = r_st | r_so;
         exp_sda = r_dt | r_do;
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (10) @(negedge clk);

      // Upstream holding SDA low (long START) must not trigger recovery.
      $display("[TB] upstream start hold");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      busy_cycles = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_cycles++;
      end
      checkOutput("start_hold_no_recovery", busy_cycles, 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (10) @(negedge clk);

      // force_clear on a healthy bus; a second request while busy is ignored.
      $display("[TB] force_clear");
      exp_q.push_back(modelRecovery(0));
      pushes++;
      force_clear = 1'b1;
      @(negedge clk);
      force_clear = 1'b0;
      checkOutput("force_busy", busy, 1);
      repeat (2) @(negedge clk);
      force_clear = 1'b1;
      @(negedge clk);
      force_clear = 1'b0;
      waitCompletion(lat, 400);
      checkOutput("force_completed", clear_done | clear_fail, 1);
      repeat (10) @(negedge clk);

      // With enable low a stuck bus is never acted on.
      $display("[TB] enable gating");
      enable = 1'b0;
      slave_release_n = 1000;
      slave_edges = 0;
      slave_hold = 1'b1;
      ext_sda = 1'b0;
      busy_cycles = 0;
      repeat (80) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_cycles++;
      end
      checkOutput("disabled_no_recovery", busy_cycles, 0);
      slave_hold = 1'b0;
      ext_sda = 1'b1;
      repeat (6) @(negedge clk);
      enable = 1'b1;
      repeat (4) @(negedge clk);

      // Automatic recovery: the slave lets go after the 3rd pulse, then random.
      $display("[TB] auto recovery");
      runSlaveRecovery(3, 1'b0);
      repeat (10) @(negedge clk);
      for (int r = 0; r < 3; r++) begin
         runSlaveRecovery(int'($urandom_range(1, MAX_PULSES)), r == 1);
         repeat (10) @(negedge clk);
      end

      // Permanently stuck slave: failure, then re-detection after a full timeout.
      $display("[TB] failed recovery");
      runSlaveRecovery(1000, 1'b0);
      waitBusy(lat, 4 * STUCK_TIMEOUT);
      checkOutput("rearm_latency", lat, STUCK_TIMEOUT);
      checkOutput("rearm_scl_low", scl_t, 0);

      // Reset in PULSE_LOW releases the bus at once, with no completion pulse.
      rst = 1'b1;
      slave_hold = 1'b0;
      ext_sda = 1'b1;
      @(negedge clk);
      checkOutput("abort_scl_t", scl_t, 1);
      checkOutput("abort_sda_t", sda_t, 1);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_stuck", stuck, 0);
      checkOutput("abort_clear_done", clear_done, 0);
      checkOutput("abort_clear_fail", clear_fail, 0);
      @(negedge clk);
      rst = 1'b0;
      pulses_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (clear_done !== 1'b0 || clear_fail !== 1'b0 || busy !== 1'b0) pulses_seen++;
      end
      checkOutput("abort_quiet", pulses_seen, 0);

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_drained", exp_q.size(), 0);
      checkOutput("completion_count", completions, pushes);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
